scan_state_bank: RTL and testbench
==================================

SCAN_STATE_BANK -- requirements
Module: scan_state_bank

Interface
REQ-001 Parameter NFF, default 18, SHALL set the state-register (pseudo-primary I/O) width; legal range 1..64.
REQ-002 Parameter NPO, default 1, SHALL set the primary-output width fed to the compactor; legal range 1..16.
REQ-003 Parameter RUN_LEN, default 4, SHALL set the functional capture cycles per test; legal range 1..255.
REQ-004 Port CK input 1 SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port RST input 1 SHALL be the reset, synchronous and active-high.
REQ-006 Port START input 1 SHALL request a load-run-unload sequence.
REQ-007 Port SI input 1 SHALL be the serial scan-in data.
REQ-008 Port NS input NFF SHALL be the next-state vector from the combinational cone.
REQ-009 Port PO input NPO SHALL be the primary outputs from the combinational cone.
REQ-010 Port INJ_VALID input 1 SHALL request a single-bit state flip on the current RUN capture.
REQ-011 Port INJ_IDX input 6 SHALL select the flipped bit.
REQ-012 Port PS output NFF SHALL be the present-state vector driven to the cone.
REQ-013 Port SO output 1 SHALL be the serial scan-out, equal to PS[NFF-1].
REQ-014 Port BUSY output 1 SHALL be high in every state except IDLE.
REQ-015 Port DONE output 1 SHALL be a one-cycle completion pulse.
REQ-016 Port SIG output 16 SHALL be the compacted output signature.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN and UNLOAD, sequenced IDLE->LOAD->RUN->UNLOAD->IDLE.
REQ-018 START in IDLE SHALL move to LOAD, clear the cycle counter, and clear SIG; START outside IDLE SHALL be ignored.
REQ-019 LOAD SHALL shift PS <= {PS[NFF-2:0], SI} for exactly NFF cycles, then enter RUN.
REQ-020 RUN SHALL capture PS <= NS ^ F for exactly RUN_LEN cycles, then enter UNLOAD; F = one-hot(INJ_IDX) when INJ_VALID and INJ_IDX < NFF, else 0.
REQ-021 INJ_VALID outside RUN, or with INJ_IDX >= NFF, SHALL have no effect.
REQ-022 UNLOAD SHALL shift as in LOAD (SI still shifted in) for exactly NFF cycles, then return to IDLE with DONE high for that one transition cycle.
REQ-023 In IDLE, PS SHALL hold its value.
REQ-024 For NFF=1, the shift SHALL reduce to PS <= SI.
REQ-025 The cycle counter SHALL be 8 bits wide (64 and 255 fit) and SHALL reset to 0 on every state entry; no wrap SHALL occur.
REQ-026 The first SO bit of UNLOAD SHALL be visible in the first UNLOAD cycle, before any shift.

Reset
REQ-027 RST high SHALL force state to IDLE, PS to 0, the counter to 0, BUSY to 0, DONE to 0 and SIG to 0 at the next edge, overriding START and any sequence in progress.
REQ-028 A sequence aborted by RST SHALL NOT produce DONE.

Configuration
REQ-029 With macro SCAN_STATE_BANK_MISR_EN defined, each RUN cycle SHALL update SIG <= {SIG[14:0],0} ^ (SIG[15] ? 16'h100B : 0) ^ zero-extended PO, sampled in the same cycle as the capture; SIG SHALL hold outside RUN.
REQ-030 Without SCAN_STATE_BANK_MISR_EN, SIG SHALL be constant 0 and no compactor logic SHALL exist.

Verification
REQ-031 Reset case: RST high for 2 cycles mid-RUN -> state IDLE, PS=0, SIG=0, BUSY=0, and no DONE.
REQ-032 Load/unload case: NFF=18, RUN_LEN=1, NS=PS (loopback), SI bits of 18'h2A5C3 shifted MSB first -> UNLOAD SO stream = 18'h2A5C3 MSB first, DONE after exactly 18+1+18 cycles from START.
REQ-033 Injection case: loaded PS=0, NS=PS, INJ_VALID=1 with INJ_IDX=5 on the first RUN cycle -> unloaded value 18'h00020; the same test with INJ_IDX=40 -> 18'h00000.
REQ-034 MISR case (macro defined): NPO=1, PO=1 for RUN_LEN=4, SIG starting at 0 -> SIG=16'h000F; with the macro undefined -> SIG=16'h0000.
REQ-035 Busy case: START pulsed during LOAD and during UNLOAD -> ignored; a single DONE; a START in the cycle after DONE starts a new sequence.
REQ-036 Timing case: RUN_LEN=255 with NFF=64 -> BUSY high for exactly 383 cycles.

Source files
------------

// File: rtl/scan_state_bank.sv
// scan_state_bank: scan-chain state register bank that sequences load, functional run and unload.
// Defining SCAN_STATE_BANK_MISR_EN adds a 16-bit MISR that compacts primary outputs during RUN.
module scan_state_bank #(
    parameter int NFF = 18,
    parameter int NPO = 1,
    parameter int RUN_LEN = 4
) (
    input  logic           ck,
    input  logic           rst,
    input  logic           start,
    input  logic           si,
    input  logic [NFF-1:0] ns,
    input  logic [NPO-1:0] po,
    input  logic           inj_valid,
    input  logic [5:0]     inj_idx,
    output logic [NFF-1:0] ps,
    output logic           so,
    output logic           busy,
    output logic           done,
    output logic [15:0]    sig
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;
    state_t state, state_n;
    logic [7:0] cnt;
    logic last;
    logic [NFF-1:0] shifted, flip;

    always_ff @(posedge ck) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= (state_n != state) ? 8'd0 : cnt + ((state == IDLE) ? 8'd0 : 8'd1);
            done <= (state == UNLOAD) && last;
        end
    end

    always_comb begin
        last = cnt == ((state == RUN) ? 8'(RUN_LEN - 1) : 8'(NFF - 1));
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LOAD : IDLE;
            LOAD:    state_n = last ? RUN : LOAD;
            RUN:     state_n = last ? UNLOAD : RUN;
            default: state_n = last ? IDLE : UNLOAD;
        endcase
    end

    always_comb busy = state != IDLE;

    if (NFF == 1) begin : g_one
        assign shifted = si;
    end else begin : g_many
        assign shifted = {ps[NFF-2:0], si};
    end

    // Out-of-range indices must not alias onto a real bit, so compare before decoding.
    assign flip = (inj_valid && ({1'b0, inj_idx} < 7'(NFF))) ? NFF'(1) << inj_idx : '0;

    always_ff @(posedge ck) begin
        if (rst)
            ps <= '0;
        else if (state == RUN)
            ps <= ns ^ flip;
        else if (state != IDLE)
            ps <= shifted;
    end

    assign so = ps[NFF-1];

`ifdef SCAN_STATE_BANK_MISR_EN
    always_ff @(posedge ck) begin
        if (rst || (state == IDLE && start))
            sig <= '0;
        else if (state == RUN)
            sig <= {sig[14:0], 1'b0} ^ (sig[15] ? 16'h100B : 16'h0000) ^ 16'(po);
    end
`else
    logic unused_po;
    assign unused_po = ^po;
    assign sig = '0;
`endif
endmodule

// File: tb/tb_scan_state_bank.sv
// tb_scan_state_bank: randomized and directed checks of scan_state_bank against a phase/countdown model.
module tb_scan_state_bank;
    localparam int NA = 18;
    localparam int PA = 4;
    localparam int RA = 1;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic rst = 1'b1, start = 1'b0, si = 1'b0, inj_valid = 1'b0;
    logic [5:0] inj_idx = '0;
    logic [NA-1:0] ns = '0;
    logic [PA-1:0] po = '0;
    logic [NA-1:0] ps;
    logic so, busy, done;
    logic [15:0] sig;

    logic start_b = 1'b0, start_c = 1'b0;
    logic [63:0] ps_b;
    logic so_b, busy_b, done_b;
    logic [15:0] sig_b;
    logic [17:0] ps_c;
    logic so_c, busy_c, done_c;
    logic [15:0] sig_c;

    scan_state_bank #(.NFF(NA), .NPO(PA), .RUN_LEN(RA)) u_a (
        .ck(ck), .rst(rst), .start(start), .si(si), .ns(ns), .po(po),
        .inj_valid(inj_valid), .inj_idx(inj_idx),
        .ps(ps), .so(so), .busy(busy), .done(done), .sig(sig)
    );

    scan_state_bank #(.NFF(64), .NPO(1), .RUN_LEN(255)) u_b (
        .ck(ck), .rst(rst), .start(start_b), .si(1'b0), .ns(ps_b), .po(1'b0),
        .inj_valid(1'b0), .inj_idx(6'd0),
        .ps(ps_b), .so(so_b), .busy(busy_b), .done(done_b), .sig(sig_b)
    );

    scan_state_bank #(.NFF(18), .NPO(1), .RUN_LEN(4)) u_c (
        .ck(ck), .rst(rst), .start(start_c), .si(1'b0), .ns(ps_c), .po(1'b1),
        .inj_valid(1'b0), .inj_idx(6'd0),
        .ps(ps_c), .so(so_c), .busy(busy_c), .done(done_c), .sig(sig_c)
    );

    int n_chk = 0;
    int n_fail = 0;

    int m_ph = 0;
    int m_left = 0;
    logic [NA-1:0] m_ps = '0;
    logic [15:0] m_sig = '0;
    logic m_done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Phases: 0 idle, 1 load, 2 run, 3 unload; m_left counts cycles still owed to the phase.
    task automatic model_step();
        m_done = 1'b0;
        if (rst) begin
            m_ph = 0;
            m_left = 0;
            m_ps = '0;
            m_sig = '0;
        end else if (m_ph == 0) begin
            if (start) begin
                m_ph = 1;
                m_left = NA;
                m_sig = '0;
            end
        end else if (m_ph == 2) begin
            m_ps = ns;
            if (inj_valid && inj_idx < NA) m_ps[inj_idx] = ~m_ps[inj_idx];
`ifdef SCAN_STATE_BANK_MISR_EN
            m_sig = ((m_sig << 1) ^ (m_sig[15] ? 16'h100B : 16'h0000)) ^ 16'(po);
`endif
            m_left--;
            if (m_left == 0) begin
                m_ph = 3;
                m_left = NA;
            end
        end else begin
            m_ps = (m_ps << 1) | NA'(si);
            m_left--;
            if (m_left == 0) begin
                m_done = (m_ph == 3);
                m_ph = (m_ph == 1) ? 2 : 0;
                m_left = RA;
            end
        end
    endtask

    task automatic cyc();
        @(posedge ck);
        model_step();
        #1;
        chk("ps", ps, m_ps);
        chk("so", so, m_ps[NA-1]);
        chk("busy", busy, m_ph != 0);
        chk("done", done, m_done);
        chk("sig", sig, m_sig);
    endtask

    task automatic run_seq(input logic [NA-1:0] pat, input logic iv, input logic [5:0] idx,
                           input logic noisy, output logic [NA-1:0] unl, output int lat);
        start = 1'b1;
        lat = 0;
        cyc();
        for (int i = 0; i < NA; i++) begin
            si = pat[NA-1-i];
            start = noisy & 1'($urandom_range(1));
            inj_valid = noisy & 1'($urandom_range(1));
            inj_idx = 6'($urandom_range(0, 20));
            cyc();
            lat++;
        end
        for (int i = 0; i < RA; i++) begin
            start = 1'b0;
            si = 1'($urandom);
            ns = m_ps;
            inj_valid = (i == 0) && iv;
            inj_idx = idx;
            po = PA'($urandom);
            cyc();
            lat++;
        end
        inj_valid = 1'b0;
        for (int i = 0; i < NA; i++) begin
            unl[NA-1-i] = so;
            si = 1'($urandom);
            start = noisy & 1'($urandom_range(1));
            cyc();
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && m_ph != 0; i++) cyc();
        chk("drain_idle", busy, 1'b0);
    endtask

    initial begin
        logic [NA-1:0] unl;
        logic [NA-1:0] pat;
        int lat;
        int n;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_ps", ps, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sig", sig, 0);

        pat = 18'h2A5C3;
        run_seq(pat, 1'b0, 6'd0, 1'b0, unl, lat);
        chk("ld_unload", unl, pat);
        chk("ld_done", done, 1'b1);
        chk("ld_latency", lat, 37);

        run_seq('0, 1'b1, 6'd5, 1'b0, unl, lat);
        chk("inj_5", unl, 18'h00020);
        run_seq('0, 1'b1, 6'd40, 1'b0, unl, lat);
        chk("inj_40", unl, 18'h00000);
        run_seq('0, 1'b1, 6'd17, 1'b0, unl, lat);
        chk("inj_17", unl, 18'h20000);

        pat = NA'($urandom);
        run_seq(pat, 1'b0, 6'd0, 1'b1, unl, lat);
        chk("busy_unload", unl, pat);
        chk("busy_done", done, 1'b1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_busy", busy, 1'b1);
        drain();

        start = 1'b1;
        cyc();
        start = 1'b0;
        si = 1'b1;
        for (int i = 0; i < NA; i++) cyc();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("abort_ps", ps, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sig", sig, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            n += int'(done);
        end
        chk("abort_nodone", n, 0);

        start_c = 1'b1;
        cyc();
        start_c = 1'b0;
        n = 0;
        while (!done_c && n < 100) begin
            cyc();
            n++;
        end
        chk("misr_latency", n, 40);
`ifdef SCAN_STATE_BANK_MISR_EN
        chk("misr_sig", sig_c, 16'h000F);
`else
        chk("misr_sig", sig_c, 16'h0000);
`endif

        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        n = int'(busy_b);
        while (busy_b && n < 1000) begin
            cyc();
            if (busy_b) n++;
        end
        chk("busy_len", n, 383);
        chk("b_done", done_b, 1'b1);
        chk("b_ps_hold", ps_b, 64'd0);

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(63) == 0);
            start = ($urandom_range(3) == 0);
            si = 1'($urandom);
            ns = NA'($urandom);
            inj_valid = 1'($urandom);
            inj_idx = 6'($urandom_range(0, 25));
            po = PA'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
